// File: rtl/parallel_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : parallel_adder_tree
//  Description : Final reduction stage of the parallel shift-add multiplier.
//                Sums the WIDTH packed partial products coming out of the
//                shifter stage with a registered binary adder tree (one
//                register per tree level) and presents the product through
//                a valid/ready handshake. A single advance signal stalls or
//                advances every stage at once.
//  Ports       : clk            - clock, rising-edge active
//                rst            - synchronous reset, active-high
//                add_valid      - partial-product vector valid
//                add_ready      - vector accepted this cycle (combinational)
//                add_din        - packed partial products, slice a at
//                                 add_din[a*2*WIDTH +: 2*WIDTH]
//                product_valid  - product_dout valid
//                product_ready  - downstream accepts product_dout
//                product_dout   - sum of all slices, mod 2^(2*WIDTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module parallel_adder_tree #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     add_valid,
    output logic                     add_ready,
    input  logic [2*WIDTH*WIDTH-1:0] add_din,
    output logic                     product_valid,
    input  logic                     product_ready,
    output logic [2*WIDTH-1:0]       product_dout
);

    localparam int DW     = 2 * WIDTH;
    localparam int LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
    localparam int LEAVES = 1 << LEVELS;
    // Registered internal nodes of a complete binary tree over LEAVES leaves.
    localparam int NODES  = LEAVES - 1;

    logic              w_adv;
    logic [DW-1:0]     r_tree [NODES];
    // Heap-ordered view of the whole tree: entries 0..NODES-1 are the adder
    // registers (root at 0), entries NODES..2*LEAVES-2 are the input slices.
    // Node i sums entries 2i+1 and 2i+2, so every leaf-to-root path crosses
    // exactly LEVELS registers and all partial products stay aligned.
    logic [DW-1:0]     w_all  [2*LEAVES-1];
    logic [LEVELS-1:0] r_valid;

    // A stage may move only if the output slot is empty or being drained.
    assign w_adv         = !product_valid || product_ready;
    assign add_ready     = w_adv;
    assign product_valid = r_valid[LEVELS-1];
    assign product_dout  = r_tree[0];

    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
        assign w_all[gi] = r_tree[gi];
    end

    // Slices beyond WIDTH pad the tree out to a power of two with zeros.
    for (genvar gj = 0; gj < LEAVES; gj++) begin : g_leaf
        if (gj < WIDTH) begin : g_slice
            assign w_all[NODES+gj] = add_din[gj*DW +: DW];
        end else begin : g_pad
            assign w_all[NODES+gj] = '0;
        end
    end

    // Data registers load whenever the pipe advances; contents under a
    // cleared valid bit are don't-care. Carries past DW bits are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                r_tree[i] <= '0;
            end
        end else if (w_adv) begin
            for (int i = 0; i < NODES; i++) begin
                r_tree[i] <= w_all[2*i+1] + w_all[2*i+2];
            end
        end
    end

    // Valid bits shift in lockstep with the data; bubbles are carried, not
    // squeezed out.
    if (LEVELS == 1) begin : g_valid_single
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
            end else if (w_adv) begin
                r_valid[0] <= add_valid;
            end
        end
    end else begin : g_valid_shift
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= '0;
            end else if (w_adv) begin
                r_valid <= {r_valid[LEVELS-2:0], add_valid};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_adder_tree.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parallel_adder_tree
//  Description : Directed self-checking bench for parallel_adder_tree with
//                WIDTH=4 (two tree levels). A table of hand-computed vectors
//                is streamed back-to-back, followed by hand-written sequences
//                for reset, exact latency, stall/backpressure and reset while
//                a vector is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_adder_tree;

    localparam int WIDTH  = 4;
    localparam int DW     = 2 * WIDTH;
    localparam int LEVELS = 2;

    logic                     clk;
    logic                     rst;
    logic                     add_valid;
    logic                     add_ready;
    logic [2*WIDTH*WIDTH-1:0] add_din;
    logic                     product_valid;
    logic                     product_ready;
    logic [DW-1:0]            product_dout;

    int checks;
    int failures;

    typedef struct {
        logic [2*WIDTH*WIDTH-1:0] din;
        logic [DW-1:0]            exp;
    } vec_t;

    vec_t vecs [7];

    parallel_adder_tree #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .add_valid     (add_valid),
        .add_ready     (add_ready),
        .add_din       (add_din),
        .product_valid (product_valid),
        .product_ready (product_ready),
        .product_dout  (product_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        add_valid     = 1'b0;
        add_din       = '0;
        product_ready = 1'b1;

        // Slices listed MSB first: slice3 slice2 slice1 slice0.
        vecs[0] = '{32'h68001A0D, 8'h8F}; // 13*11 = 143
        vecs[1] = '{32'h783C1E0F, 8'hE1}; // 15*15 = 225
        vecs[2] = '{32'h00000000, 8'h00}; // 0*9
        vecs[3] = '{32'hFFFFFFFF, 8'hFC}; // 4*255 = 1020 mod 256
        vecs[4] = '{32'h00000001, 8'h01}; // 1*1
        vecs[5] = '{32'h001C0007, 8'h23}; // 7*5 = 35
        vecs[6] = '{32'h00241200, 8'h36}; // 9*6 = 54

        // ---------------- reset held two cycles ----------------
        #1;
        chk("reset_add_ready_comb", 32'(add_ready), 32'd1);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset_product_valid", 32'(product_valid), 32'd0);
            chk("reset_product_dout", 32'(product_dout), 32'd0);
            chk("reset_add_ready", 32'(add_ready), 32'd1);
        end
        rst = 1'b0;
        tick();
        chk("post_reset_product_valid", 32'(product_valid), 32'd0);
        chk("post_reset_add_ready", 32'(add_ready), 32'd1);

        // ---------------- exact latency, single 13*11 ----------------
        add_din   = 32'h68001A0D;
        add_valid = 1'b1;
        tick();
        add_valid = 1'b0;
        add_din   = '0;
        chk("lat_not_early", 32'(product_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(product_valid), 32'd1);
        chk("lat_dout", 32'(product_dout), 32'h8F);
        tick();
        chk("lat_one_cycle", 32'(product_valid), 32'd0);

        // ---------------- table streamed back-to-back ----------------
        // Vector e is driven in iteration e and must appear LEVELS
        // iterations later, one product per cycle with ready held high.
        for (int e = 0; e < 7 + LEVELS + 1; e++) begin
            if (e >= LEVELS && e < 7 + LEVELS) begin
                chk("stream_valid", 32'(product_valid), 32'd1);
                chk("stream_dout", 32'(product_dout), 32'(vecs[e-LEVELS].exp));
            end else begin
                chk("stream_idle", 32'(product_valid), 32'd0);
            end
            chk("stream_add_ready", 32'(add_ready), 32'd1);
            if (e < 7) begin
                add_din   = vecs[e].din;
                add_valid = 1'b1;
            end else begin
                add_din   = '0;
                add_valid = 1'b0;
            end
            tick();
        end

        // ---------------- stall with a second vector in flight ----------------
        add_din   = 32'h68001A0D;
        add_valid = 1'b1;
        tick();
        add_din   = 32'h783C1E0F;
        tick();
        add_valid     = 1'b0;
        add_din       = '0;
        product_ready = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(product_valid), 32'd1);
            chk("stall_dout", 32'(product_dout), 32'h8F);
            chk("stall_add_ready", 32'(add_ready), 32'd0);
            tick();
        end
        product_ready = 1'b1;
        #1;
        chk("release_add_ready", 32'(add_ready), 32'd1);
        tick();
        chk("release_second_valid", 32'(product_valid), 32'd1);
        chk("release_second_dout", 32'(product_dout), 32'hE1);
        tick();
        chk("release_drained", 32'(product_valid), 32'd0);

        // ---------------- reset while a vector is in flight ----------------
        add_din   = 32'h783C1E0F;
        add_valid = 1'b1;
        tick();
        add_valid = 1'b0;
        add_din   = '0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_dout_cleared", 32'(product_dout), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("midrst_no_product", 32'(product_valid), 32'd0);
            tick();
        end
        add_din   = 32'hFFFFFFFF;
        add_valid = 1'b1;
        tick();
        add_valid = 1'b0;
        add_din   = '0;
        chk("midrst_next_not_early", 32'(product_valid), 32'd0);
        tick();
        chk("midrst_next_valid", 32'(product_valid), 32'd1);
        chk("midrst_next_dout", 32'(product_dout), 32'hFC);
        tick();
        chk("midrst_next_done", 32'(product_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
